// File: rtl/mult_share_arbiter_pkg.sv
// mult_share_arbiter_pkg: state encoding, operand width and unit latency shared by the
// multiply-sharing arbiter and its round-robin grant logic.
package mult_share_arbiter_pkg;
    localparam int OPW = 8;
    localparam int MUL_LAT = 14;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;
    function automatic int rr_index(input int ptr, input int k, input int n);
        return (ptr + k) % n;
    endfunction
endpackage

// File: rtl/mult_share_arbiter_rr_arbiter_comb.sv
// rr_arbiter_comb: picks the first valid requester scanning upward from rr_ptr, wrapping;
// returns it both one-hot and encoded.
module rr_arbiter_comb
    import mult_share_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   gidx
);
    // Scan from the farthest offset down so the nearest valid requester is written last.
    always_comb begin
        grant = '0;
        gidx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[IW'(rr_index(int'(rr_ptr), k, NREQ))]) begin
                grant = NREQ'(1) << rr_index(int'(rr_ptr), k, NREQ);
                gidx = IW'(rr_index(int'(rr_ptr), k, NREQ));
            end
        end
    end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: time-shares one 8-bit multiply unit among NREQ requesters with
// round-robin arbitration, held operands, and a watchdog that turns a lost done into an error.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TIMEOUT = 31,
    parameter int CW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [OPW-1:0]      rsp_data,
    output logic                rsp_err,
    output logic                mul_start,
    output logic [OPW-1:0]      mul_a,
    output logic [OPW-1:0]      mul_b,
    input  logic                mul_done,
    input  logic [OPW-1:0]      mul_c,
    output logic                busy
);
    localparam int IW = $clog2(NREQ);

    state_e          state_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   gid_q;
    logic [CW-1:0]   wd_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [OPW-1:0]  rsp_data_q;
    logic            rsp_err_q;
    logic            mul_start_q;
    logic [OPW-1:0]  mul_a_q;
    logic [OPW-1:0]  mul_b_q;
    logic            busy_q;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;

    rr_arbiter_comb #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_valid(req_valid),
        .rr_ptr(rr_ptr_q),
        .grant(grant),
        .gidx(gidx)
    );

    assign req_ready = (state_q == IDLE) ? grant : '0;

    // Outputs are registered alongside the state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            gid_q <= '0;
            wd_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|grant) begin
                    mul_a_q <= req_a[int'(gidx)*OPW +: OPW];
                    mul_b_q <= req_b[int'(gidx)*OPW +: OPW];
                    gid_q <= gidx;
                    mul_start_q <= 1'b1;
                    busy_q <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    mul_start_q <= 1'b0;
                    wd_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: if (mul_done) begin
                    rsp_data_q <= mul_c;
                    rsp_err_q <= 1'b0;
                    rsp_valid_q <= NREQ'(1) << gid_q;
                    state_q <= RESP;
                end else if (wd_q == CW'(TIMEOUT - 1)) begin
                    rsp_data_q <= '0;
                    rsp_err_q <= 1'b1;
                    rsp_valid_q <= NREQ'(1) << gid_q;
                    state_q <= RESP;
                end else begin
                    wd_q <= wd_q + 1'b1;
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    rr_ptr_q <= (gid_q == IW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
                    busy_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err = rsp_err_q;
    assign mul_start = mul_start_q;
    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign busy = busy_q;
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one 8-bit signed multiply unit among NREQ requesters in the calculator datapath.
- Arbitrates round-robin between requests and latches the winner's operands.
- Holds the operands stable on the unit while it runs, pulses its start, and waits for its done pulse.
- Returns the product to the granting requester with a tagged response; a watchdog converts a missing done into an error response.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 31, max cycles waited for mul_done after start; must exceed the unit latency (14).
- CW, 5, watchdog counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester request
- req_a  in  8*NREQ  operand A, slice i for requester i
- req_b  in  8*NREQ  operand B, slice i for requester i
- req_ready  out  NREQ  combinational accept, one-hot or zero
- rsp_valid  out  NREQ  registered one-cycle response pulse, one-hot
- rsp_data  out  8  product, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- mul_start  out  1  start pulse to the multiply unit
- mul_a  out  8  operand A to the unit, held for the whole operation
- mul_b  out  8  operand B to the unit, held for the whole operation
- mul_done  in  1  unit completion pulse
- mul_c  in  8  unit result, sampled with mul_done
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, rr_ptr=0, and every registered output is 0 (rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b, busy). Watchdog=0.
- Reset is honoured in any state, including mid-operation. The in-flight operation is dropped with no response, and mul_start stays low in the following cycle.
- Request handshake: the requester drives req_valid with its operands and holds both until it sees req_ready high. Transfer happens on the edge where req_valid[i]&req_ready[i].
- Arbitration (IDLE only): g = first index i scanning rr_ptr, rr_ptr+1, ... mod NREQ with req_valid[i]=1. req_ready[g]=1 in that same cycle; all other req_ready are 0.
- In any non-IDLE state, req_ready is all zero.

State machine:
- IDLE:
  - On accept, latch mul_a<=req_a[g], mul_b<=req_b[g] and gid<=g; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - mul_start=1 for exactly this one cycle; watchdog<=0; go to WAIT.
- WAIT:
  - mul_start=0; mul_a and mul_b unchanged.
  - If mul_done=1: rsp_data<=mul_c, rsp_err<=0; go to RESP.
  - Else if watchdog==TIMEOUT-1: rsp_data<=0, rsp_err<=1; go to RESP.
  - Else watchdog increments.
  - If mul_done arrives in the same cycle as the timeout, done wins and rsp_err=0.
- RESP:
  - rsp_valid[gid]=1 for one cycle; rr_ptr<=(gid+1) mod NREQ; go to IDLE.
  - rsp_data and rsp_err hold their values until the next RESP.

Timing and boundary rules:
- Latency: response pulse is one cycle after the cycle mul_done is sampled. Minimum occupancy per operation = accept + ISSUE + unit latency + RESP.
- mul_done seen in IDLE, ISSUE or RESP is ignored.
- A requester whose req_valid drops before being granted is simply skipped.
- The requester just granted has lowest priority in the next arbitration. No requester waits more than NREQ-1 operations.
- The block does no arithmetic: mul_c passes through unchanged, including the unit's overflow-to-zero results.
- The block does not consume a simultaneous new request during RESP; that request is granted on the next IDLE cycle.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3;
  - operand width constant OPW=8;
  - unit latency constant MUL_LAT=14, used for TIMEOUT sanity checks and the bench model.
- One natural sub-module: rr_arbiter_comb. Pure combinational; inputs req_valid and rr_ptr; outputs the one-hot grant and the encoded index.

Test Plan:
- Bench uses a behavioural unit: mul_done pulses 14 cycles after the mul_start cycle, with mul_c = low byte of a*b.
- Single request: req0 with a=5, b=3. Expect req_ready[0] in the same cycle, mul_start 1 cycle later with mul_a=5, mul_b=3 held, then rsp_valid=4'b0001, rsp_data=15, rsp_err=0 one cycle after done.
- Contention: all four requesters valid continuously with a=i+1, b=2. Expect grant order 0,1,2,3,0 and responses 2,4,6,8 on matching rsp_valid bits.
- Fairness after grant: req1 and req3 held valid, last grant 1. Expect the next grant to go to 3, then to 1.
- Timeout: unit model never pulses done. Expect a response TIMEOUT cycles after WAIT entry with rsp_err=1 and rsp_data=0, then the arbiter returns to IDLE and serves the next request normally.
- Reset mid-WAIT: assert rst for 1 cycle, 5 cycles after mul_start. Expect all outputs 0, no rsp_valid, busy=0, and rr_ptr=0 (the next concurrent req0 and req2 grant req0).
- Stray done: pulse mul_done while IDLE. Expect no rsp_valid and no state change.
